gate_checker: RTL and testbench
===============================

Name: gate_checker

Overview:
- Self-checking stimulus/response engine for the two-input gate primitive block (AND, OR, NOR, NAND, XOR, XNOR, NOT, BUF).
- Drives the block's a/b inputs through all four input vectors and samples its eight outputs.
- Compares the outputs against a golden truth table and reports per-gate pass/fail.
- Sits beside the gate block on the lab board / testbench top; `start` comes from a button or the bench.

Parameters:
- SETTLE_CYCLES, 1, cycles to hold each vector before sampling; legal range 1..15; 0 is illegal and must be rejected at elaboration.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  level; sampled only in IDLE; starts one full sweep.
- a  output  1  stimulus to the gate block input a.
- b  output  1  stimulus to the gate block input b.
- y  input  8  gate block outputs, packed {buf, not, xnor, xor, nand, nor, or, and}, i.e. y[0]=AND … y[7]=BUF.
- busy  output  1  high from the cycle after start is accepted until FINISH, inclusive.
- done  output  1  one-cycle pulse in FINISH.
- pass  output  1  result of the last completed sweep; 1 = no mismatches.
- err_mask  output  8  sticky per-gate failure bits for the last or current sweep.
- err_count  output  3  number of vectors (0..4) with at least one mismatching gate.

Behaviour:
- Reset values (rst high at an edge):
  - state=IDLE; a=0, b=0.
  - busy=0, done=0, pass=0, err_mask=0, err_count=0.
  - Internal vector index and settle counter are 0.
- Reset mid-sweep aborts immediately: no done pulse, results cleared, a/b return to 0.
- Vector order: index 0..3 with {a,b}=index, i.e. 00, 01, 10, 11. a and b are registered outputs.
- Expected outputs for vector (a,b):
  - AND=a&b, OR=a|b, NOR=~(a|b), NAND=~(a&b).
  - XOR=a^b, XNOR=~(a^b), NOT=~a, BUF=a.
- States:
  - IDLE: busy=0.
    - If start=1: index<=0, {a,b}<=00, settle counter<=0, err_mask<=0, err_count<=0, pass<=0, go to SETTLE.
    - Otherwise hold. The previous pass/err_* values remain visible.
  - SETTLE: busy=1, a/b held.
    - Counter increments each cycle.
    - When counter==SETTLE_CYCLES-1, go to CHECK.
  - CHECK: busy=1; sample y in this cycle.
    - mism = y XOR expected(a,b); err_mask <= err_mask | mism.
    - If mism!=0, err_count increments (saturating is not needed; max is 4).
    - If index==3: go to FINISH.
    - Else: index+1, drive the next {a,b} on the same edge, clear counter, go to SETTLE.
  - FINISH: busy=1, done=1 for exactly this cycle.
    - pass <= (final err_mask==0), computed including the last CHECK's mismatches.
    - Go to IDLE.
- Latency: done is high in cycle 4*(SETTLE_CYCLES+1)+1 after the start-sampling edge; 9 cycles for the default.
- start while busy is ignored.
- start held high through FINISH begins a new sweep on the first IDLE cycle; pass and err_* are then cleared.
- y is treated as settled combinational logic. X/Z on y counts as a mismatch in simulation: compare with a case-inequality per bit.
- a/b hold their last value (11) after FINISH until the next start or reset.

Decomposition:
- Package gate_chk_pkg:
  - State encoding: IDLE, SETTLE, CHECK, FINISH.
  - NUM_VEC=4.
  - Gate bit-index constants GATE_AND=0 … GATE_BUF=7.
  - Function exp_out(a,b) returning the 8-bit expected vector.
- One sub-module: gate_chk_golden, combinational, {a,b} -> 8-bit expected vector, built from exp_out. It is instantiated once in gate_checker.
- FSM, counters and scoreboard stay in the top.

Test Plan:
- Correct gate block connected, default parameter, start pulsed one cycle:
  - {a,b} sequence is 00, 01, 10, 11.
  - done is high only in cycle 9; busy is high cycles 1–9.
  - Result: pass=1, err_mask=8'h00, err_count=0.
- Fault model with NAND stuck-at-0 (y[3]=0):
  - Mismatches on vectors 00, 01 and 10.
  - Result: err_mask=8'h08, err_count=3, pass=0.
- Fault model with XOR and XNOR swapped:
  - Result: err_mask=8'h30, err_count=4, pass=0.
- SETTLE_CYCLES=3, correct block:
  - Each vector is held 4 cycles; done is at cycle 17.
  - Result: pass=1.
- rst asserted in cycle 5 of a sweep:
  - Next cycle: IDLE, a=b=0, busy=0, pass=0, err_mask=0.
  - No done pulse ever appears for that sweep.
- start held high continuously:
  - Back-to-back sweeps; done pulses at cycles 9 and 19.
  - Pulses on start during busy cause no disturbance.
  - Results are cleared at each new start.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate-block checker: FSM states, gate bit
// positions and the golden truth-table function.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_FINISH
  } state_e;

  localparam int NUM_VEC = 4;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOR  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_XOR  = 4;
  localparam int GATE_XNOR = 5;
  localparam int GATE_NOT  = 6;
  localparam int GATE_BUF  = 7;

  // Expected gate-block outputs for one input vector, packed like y.
  function automatic logic [7:0] exp_out(input logic a, input logic b);
    logic [7:0] e;
    e            = '0;
    e[GATE_AND]  = a & b;
    e[GATE_OR]   = a | b;
    e[GATE_NOR]  = ~(a | b);
    e[GATE_NAND] = ~(a & b);
    e[GATE_XOR]  = a ^ b;
    e[GATE_XNOR] = ~(a ^ b);
    e[GATE_NOT]  = ~a;
    e[GATE_BUF]  = a;
    return e;
  endfunction

endpackage

// File: rtl/gate_chk_golden.sv
// Combinational golden model: maps the current {a,b} stimulus to the 8-bit
// vector the gate block should produce.
module gate_chk_golden
  import gate_chk_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [7:0] exp_y
);

  assign exp_y = exp_out(a, b);

endmodule

// File: rtl/gate_checker.sv
// Stimulus/response engine that sweeps the gate block through all four input
// vectors and scores its outputs against the golden truth table.
module gate_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [7:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_mask,
  output logic [2:0] err_count
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("gate_checker: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ab_q, ab_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] err_mask_q, err_mask_d;
  logic [2:0] err_count_q, err_count_d;
  logic       pass_q, pass_d;
  logic [7:0] exp_y;
  logic [7:0] mism;

  gate_chk_golden u_golden (
    .a     (ab_q[1]),
    .b     (ab_q[0]),
    .exp_y (exp_y)
  );

  // Case-inequality so X/Z on y is scored as a mismatch in simulation.
  always_comb begin
    mism = '0;
    for (int i = 0; i < 8; i++) begin
      mism[i] = (y[i] !== exp_y[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ab_d        = ab_q;
    cnt_d       = cnt_q;
    err_mask_d  = err_mask_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d       = '0;
          ab_d        = '0;
          cnt_d       = '0;
          err_mask_d  = '0;
          err_count_d = '0;
          pass_d      = 1'b0;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        err_mask_d = err_mask_q | mism;
        if (mism != 8'h00) begin
          err_count_d = err_count_q + 3'd1;
        end
        if (idx_q == 2'(NUM_VEC - 1)) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 2'd1;
          ab_d    = idx_q + 2'd1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_FINISH: begin
        // err_mask_q already holds the last CHECK's contribution here.
        pass_d  = (err_mask_q == 8'h00);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ab_q        <= '0;
      cnt_q       <= '0;
      err_mask_q  <= '0;
      err_count_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ab_q        <= ab_d;
      cnt_q       <= cnt_d;
      err_mask_q  <= err_mask_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
    end
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign pass      = pass_q;
  assign err_mask  = err_mask_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker: drives a behavioural gate block with
// selectable faults into two checker instances (SETTLE_CYCLES 1 and 3).
module tb_gate_checker;

  logic       clk;
  logic       rst;
  logic       start1, start3;
  logic       a1, b1, a3, b3;
  logic [7:0] y1, y3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [7:0] err_mask1, err_mask3;
  logic [2:0] err_count1, err_count3;
  logic [1:0] mode1, mode3;

  int n_vec;
  int n_err;

  // Gate block model; mode 1 = NAND stuck-at-0, mode 2 = XOR/XNOR swapped.
  function automatic logic [7:0] gate_model(input logic a, input logic b, input logic [1:0] mode);
    logic [7:0] g;
    g = {a, ~a, ~(a ^ b), a ^ b, ~(a & b), ~(a | b), a | b, a & b};
    if (mode == 2'd1) g[3] = 1'b0;
    if (mode == 2'd2) begin
      g[4] = ~(a ^ b);
      g[5] = a ^ b;
    end
    return g;
  endfunction

  assign y1 = gate_model(a1, b1, mode1);
  assign y3 = gate_model(a3, b3, mode3);

  gate_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_mask(err_mask1), .err_count(err_count1)
  );

  gate_checker #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .y(y3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_mask(err_mask3), .err_count(err_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulses start on instance 1 and returns in cycle 1 of the sweep.
  task automatic applyStimulus();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  // Walks a SETTLE_CYCLES=1 sweep from cycle 1; optional start pulse while busy.
  task automatic runSweep1(input int ncyc, input int pulse_cyc);
    for (int c = 1; c <= ncyc; c++) begin
      start1 = (c == pulse_cyc);
      if (c <= 8) checkOutput("ab1", {6'b0, a1, b1}, 8'((c - 1) / 2));
      checkOutput("busy1", {7'b0, busy1}, {7'b0, c <= 9});
      checkOutput("done1", {7'b0, done1}, {7'b0, c == 9});
      tick();
    end
    start1 = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    mode1  = 2'd0;
    mode3  = 2'd0;
    repeat (2) tick();

    checkOutput("rst_a",     {7'b0, a1},    8'h00);
    checkOutput("rst_b",     {7'b0, b1},    8'h00);
    checkOutput("rst_busy",  {7'b0, busy1}, 8'h00);
    checkOutput("rst_done",  {7'b0, done1}, 8'h00);
    checkOutput("rst_pass",  {7'b0, pass1}, 8'h00);
    checkOutput("rst_mask",  err_mask1,     8'h00);
    checkOutput("rst_count", {5'b0, err_count1}, 8'h00);
    rst = 1'b0;
    tick();

    $display("[TB] NAND stuck-at-0 sweep");
    mode1 = 2'd1;
    applyStimulus();
    runSweep1(11, 0);
    checkOutput("nand_mask",  err_mask1,          8'h08);
    checkOutput("nand_count", {5'b0, err_count1}, 8'h03);
    checkOutput("nand_pass",  {7'b0, pass1},      8'h00);

    $display("[TB] XOR/XNOR swapped sweep");
    mode1 = 2'd2;
    applyStimulus();
    runSweep1(11, 0);
    checkOutput("swap_mask",  err_mask1,          8'h30);
    checkOutput("swap_count", {5'b0, err_count1}, 8'h04);
    checkOutput("swap_pass",  {7'b0, pass1},      8'h00);

    $display("[TB] correct block sweep with start pulse while busy");
    mode1 = 2'd0;
    applyStimulus();
    runSweep1(11, 3);
    checkOutput("good_mask",  err_mask1,          8'h00);
    checkOutput("good_count", {5'b0, err_count1}, 8'h00);
    checkOutput("good_pass",  {7'b0, pass1},      8'h01);

    $display("[TB] SETTLE_CYCLES=3 sweep");
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      if (c <= 16) checkOutput("ab3", {6'b0, a3, b3}, 8'((c - 1) / 4));
      checkOutput("busy3", {7'b0, busy3}, {7'b0, c <= 17});
      checkOutput("done3", {7'b0, done3}, {7'b0, c == 17});
      tick();
    end
    checkOutput("s3_pass", {7'b0, pass3}, 8'h01);
    checkOutput("s3_mask", err_mask3,     8'h00);

    $display("[TB] reset in cycle 5 of a sweep");
    mode1 = 2'd2;
    applyStimulus();
    repeat (4) tick();
    checkOutput("mid_mask", err_mask1, 8'h30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy",  {7'b0, busy1}, 8'h00);
    checkOutput("abort_ab",    {6'b0, a1, b1}, 8'h00);
    checkOutput("abort_pass",  {7'b0, pass1}, 8'h00);
    checkOutput("abort_mask",  err_mask1,     8'h00);
    checkOutput("abort_count", {5'b0, err_count1}, 8'h00);
    for (int c = 0; c < 12; c++) begin
      checkOutput("abort_done", {7'b0, done1}, 8'h00);
      tick();
    end

    $display("[TB] start held high");
    mode1  = 2'd2;
    start1 = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      checkOutput("held_done", {7'b0, done1}, {7'b0, (c == 9) || (c == 19)});
      checkOutput("held_busy", {7'b0, busy1}, {7'b0, (c != 10) && (c <= 19)});
      if (c == 10) begin
        checkOutput("held1_mask",  err_mask1,          8'h30);
        checkOutput("held1_count", {5'b0, err_count1}, 8'h04);
        checkOutput("held1_pass",  {7'b0, pass1},      8'h00);
        mode1 = 2'd0;
      end
      if (c == 11) begin
        checkOutput("held_clr_mask",  err_mask1,          8'h00);
        checkOutput("held_clr_count", {5'b0, err_count1}, 8'h00);
      end
      if (c == 19) start1 = 1'b0;
      if (c == 20) begin
        checkOutput("held2_pass",  {7'b0, pass1},      8'h01);
        checkOutput("held2_mask",  err_mask1,          8'h00);
        checkOutput("held2_ab",    {6'b0, a1, b1},     8'h03);
      end
      tick();
    end
    checkOutput("held_end_busy", {7'b0, busy1}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
